// File: rtl/acc_sched.sv
// Round-robin scheduler sharing one matrix-multiply unit among NUM_REQ requesters.
// Grants one requester, starts the unit, waits for a done edge or timeout, then acks.
//
// state | meaning
// IDLE  | no operation; arbitrate among pending requests
// START | grant held, mm_start pulsed, timeout counter cleared
// WAIT  | waiting for a rising edge on mm_done or timeout
// RESP  | ack (and err on timeout) pulsed to the granted requester
module acc_sched #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         err,
    output logic                       mm_start,
    input  logic                       mm_done,
    output logic                       busy,
    output logic [CNT_W-1:0]           op_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   tmr, tmr_nxt;
    logic [IDX_W-1:0]   last_winner, last_nxt;
    logic [IDX_W-1:0]   idx_nxt, win, cand;
    logic [NUM_REQ-1:0] gnt_nxt, ack_nxt, err_nxt;
    logic [CNT_W-1:0]   op_cnt_nxt;
    logic               start_nxt, busy_nxt, done_q, done_edge, found;

    assign done_edge = mm_done & ~done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= '0;
            gnt_idx     <= '0;
            ack         <= '0;
            err         <= '0;
            mm_start    <= 1'b0;
            busy        <= 1'b0;
            op_cnt      <= '0;
            tmr         <= '0;
            done_q      <= 1'b0;
            last_winner <= IDX_W'(NUM_REQ - 1);
        end else begin
            state       <= state_nxt;
            gnt         <= gnt_nxt;
            gnt_idx     <= idx_nxt;
            ack         <= ack_nxt;
            err         <= err_nxt;
            mm_start    <= start_nxt;
            busy        <= busy_nxt;
            op_cnt      <= op_cnt_nxt;
            tmr         <= tmr_nxt;
            done_q      <= mm_done;
            last_winner <= last_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        idx_nxt    = gnt_idx;
        ack_nxt    = '0;
        err_nxt    = '0;
        start_nxt  = 1'b0;
        tmr_nxt    = tmr;
        last_nxt   = last_winner;
        op_cnt_nxt = op_cnt;
        found      = 1'b0;
        win        = '0;
        cand       = '0;

        case (state)
            IDLE: begin
                // Search begins one past the previous winner so every requester gets a turn.
                for (int i = 1; i <= NUM_REQ; i++) begin
                    cand = IDX_W'((int'(last_winner) + i) % NUM_REQ);
                    if (!found && req[cand]) begin
                        found = 1'b1;
                        win   = cand;
                    end
                end
                if (found) begin
                    state_nxt = START;
                    gnt_nxt   = NUM_REQ'(1) << win;
                    idx_nxt   = win;
                    start_nxt = 1'b1;
                end
            end
            START: begin
                state_nxt = WAIT;
                tmr_nxt   = '0;
            end
            WAIT: begin
                // A done edge wins over a coincident timeout.
                if (done_edge) begin
                    state_nxt  = RESP;
                    ack_nxt    = gnt;
                    op_cnt_nxt = op_cnt + CNT_W'(1);
                end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
                    state_nxt = RESP;
                    ack_nxt   = gnt;
                    err_nxt   = gnt;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                idx_nxt   = '0;
                last_nxt  = gnt_idx;
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule
